// File: rtl/thermal_state_encoder.sv
// Thermal-state producer: averages sensor samples over fixed windows and
// classifies each average into a 3-bit thermal state with hysteretic de-escalation.
module thermal_state_encoder #(
    parameter int DW       = 8,
    parameter int AVG_LOG2 = 2,
    parameter int T_SMALL  = 60,
    parameter int T_LG     = 80,
    parameter int T_EXT    = 100,
    parameter int HYST     = 4,
    parameter int DWELL    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    output logic          sample_ready,
    output logic [2:0]    temp_st,
    output logic [DW-1:0] avg_out,
    output logic          st_change
);

    localparam int AW  = DW + AVG_LOG2;
    localparam int CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DWW = $clog2(DWELL + 1);
    localparam logic [CW-1:0]  CNT_LAST   = CW'((1 << AVG_LOG2) - 1);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
    localparam logic [DW:0]    SAT        = {1'b0, {DW{1'b1}}};

    typedef enum logic {
        ACCUM,
        EVAL
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic [1:0]     lvl_d;
    logic [DW-1:0]  avg_out_d;
    logic [DW-1:0]  avg;
    logic [DW:0]    hyst_sum;
    logic [DW-1:0]  hyst_sat;
    logic [1:0]     up_cls;
    logic [1:0]     down_cls;
    logic           accept;

    function automatic logic [1:0] classify(input logic [DW-1:0] x);
        if (x >= DW'(T_EXT))        return 2'd3;
        else if (x >= DW'(T_LG))    return 2'd2;
        else if (x >= DW'(T_SMALL)) return 2'd1;
        else                        return 2'd0;
    endfunction

    always_comb begin
        accept   = sample_valid && sample_ready;
        avg      = DW'(acc_q >> AVG_LOG2);
        hyst_sum = {1'b0, avg} + (DW+1)'(HYST);
        hyst_sat = (hyst_sum > SAT) ? SAT[DW-1:0] : hyst_sum[DW-1:0];
        up_cls   = classify(avg);
        down_cls = classify(hyst_sat);

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        lvl_d     = temp_st[1:0];
        avg_out_d = avg_out;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + AW'(sample);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            EVAL: begin
                avg_out_d = avg;
                acc_d     = '0;
                state_d   = ACCUM;
                if (up_cls > temp_st[1:0]) begin
                    lvl_d   = up_cls;
                    dwell_d = '0;
                end else if (down_cls < temp_st[1:0]) begin
                    // Dwell reaching DWELL steps down exactly one level
                    if (dwell_q == DWELL_LAST) begin
                        lvl_d   = temp_st[1:0] - 2'd1;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DWW'(1);
                    end
                end else begin
                    dwell_d = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            dwell_q      <= '0;
            temp_st      <= '0;
            avg_out      <= '0;
            st_change    <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            temp_st      <= {1'b0, lvl_d};
            avg_out      <= avg_out_d;
            st_change    <= (lvl_d != temp_st[1:0]);
            sample_ready <= (state_d == ACCUM);
        end
    end

endmodule

// File: tb/tb_thermal_state_encoder.sv
// Randomised and directed bench for thermal_state_encoder against a
// window-level behavioural model (sample queue + integer averaging).
module tb_thermal_state_encoder;

    localparam int DW = 8;
    localparam int WIN = 4;
    localparam int T_SMALL = 60, T_LG = 80, T_EXT = 100, HYST = 4, DWELL = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic          sample_ready;
    logic [2:0]    temp_st;
    logic [DW-1:0] avg_out;
    logic          st_change;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int ready_lows = 0;

    // reference model state
    int m_q[$];
    bit m_eval;
    bit m_ready;
    int m_lvl;
    int m_dwell;
    int m_avg;
    bit m_chg;

    thermal_state_encoder #(
        .DW(DW), .AVG_LOG2(2), .T_SMALL(T_SMALL), .T_LG(T_LG),
        .T_EXT(T_EXT), .HYST(HYST), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .sample_ready(sample_ready), .temp_st(temp_st), .avg_out(avg_out),
        .st_change(st_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int classify(input int x);
        if (x >= T_EXT) return 3;
        if (x >= T_LG) return 2;
        if (x >= T_SMALL) return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_eval = 0; m_ready = 1; m_lvl = 0; m_dwell = 0; m_avg = 0; m_chg = 0;
    endfunction

    function automatic void model_window();
        int sum = 0;
        int old = m_lvl;
        int c, dn;
        foreach (m_q[i]) sum += m_q[i];
        m_q.delete();
        m_avg = sum / WIN;
        c = classify(m_avg);
        dn = classify((m_avg + HYST > 255) ? 255 : m_avg + HYST);
        if (c > m_lvl) begin
            m_lvl = c; m_dwell = 0;
        end else if (dn < m_lvl) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_lvl--; m_dwell = 0;
            end
        end else begin
            m_dwell = 0;
        end
        m_chg = (m_lvl != old);
    endfunction

    function automatic void model_edge(input bit v, input int d);
        m_chg = 0;
        if (m_eval) begin
            model_window();
            m_eval = 0;
        end else if (v && m_ready) begin
            m_q.push_back(d);
            if (m_q.size() == WIN) m_eval = 1;
        end
        m_ready = !m_eval;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] d);
        sample_valid = v;
        sample = d;
        @(posedge clk);
        model_edge(v, int'(d));
        #1;
        chk("sample_ready", int'(sample_ready), int'(m_ready));
        chk("temp_st", int'(temp_st), m_lvl);
        chk("avg_out", int'(avg_out), m_avg);
        chk("st_change", int'(st_change), int'(m_chg));
        if (st_change) pulses++;
        if (!sample_ready) ready_lows++;
    endtask

    // During EVAL the source keeps valid high with junk data that must be ignored
    task automatic send_sample(input logic [DW-1:0] d);
        if (!m_ready) step(1'b1, DW'($urandom));
        step(1'b1, d);
    endtask

    task automatic window(input logic [DW-1:0] v);
        for (int i = 0; i < WIN; i++) send_sample(v);
        step(1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        #2;
        model_reset();
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_temp_st", int'(temp_st), 0);
        chk("rst_avg_out", int'(avg_out), 0);
        chk("rst_st_change", int'(st_change), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        @(posedge clk);
        do_reset();

        // four 85s back-to-back
        p0 = pulses; ready_lows = 0;
        for (int i = 0; i < WIN; i++) step(1'b1, 8'd85);
        step(1'b0, '0);
        chk("w85_ready_low", ready_lows, 1);
        chk("w85_avg", int'(avg_out), 85);
        chk("w85_state", int'(temp_st), 2);
        chk("w85_pulses", pulses - p0, 1);

        // escalation and saturation
        send_sample(8'd104); send_sample(8'd104); send_sample(8'd106); send_sample(8'd106);
        step(1'b0, '0);
        chk("esc_avg", int'(avg_out), 105);
        chk("esc_state", int'(temp_st), 3);
        window(8'd255);
        chk("sat_avg", int'(avg_out), 255);
        chk("sat_state", int'(temp_st), 3);

        // hysteresis: avg 97 never qualifies
        for (int i = 0; i < 10; i++) window(8'd97);
        chk("hyst97_state", int'(temp_st), 3);

        // stepped de-escalation
        p0 = pulses;
        for (int i = 1; i <= 24; i++) begin
            window(8'd50);
            if (i == 7)  chk("deesc_w7", int'(temp_st), 3);
            if (i == 8)  chk("deesc_w8", int'(temp_st), 2);
            if (i == 15) chk("deesc_w15", int'(temp_st), 2);
            if (i == 16) chk("deesc_w16", int'(temp_st), 1);
            if (i == 24) chk("deesc_w24", int'(temp_st), 0);
        end
        chk("deesc_pulses", pulses - p0, 3);

        // dwell interruption
        window(8'd85);
        chk("dwell_start", int'(temp_st), 2);
        for (int i = 0; i < 7; i++) window(8'd50);
        window(8'd78);
        for (int i = 0; i < 7; i++) window(8'd50);
        chk("dwell_hold", int'(temp_st), 2);
        window(8'd50);
        chk("dwell_drop", int'(temp_st), 1);

        // reset mid-window discards partial sum
        send_sample(8'd200); send_sample(8'd200);
        do_reset();
        p0 = pulses;
        window(8'd20);
        chk("rstmid_avg", int'(avg_out), 20);
        chk("rstmid_state", int'(temp_st), 0);
        chk("rstmid_pulses", pulses - p0, 0);

        // randomised segments around the thresholds with valid gaps
        for (int s = 0; s < 80; s++) begin
            int base = $urandom_range(20, 150);
            int len = $urandom_range(8, 60);
            for (int c = 0; c < len; c++) begin
                int d = base + $urandom_range(0, 16) - 8;
                if ($urandom_range(0, 15) == 0) d = 255;
                step(($urandom % 4) != 0, DW'(d));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
